// File: rtl/i3c_regf_pkg.sv
// i3c_regf_pkg
// Shared definitions for the multi-port controller register file:
//   - register address map (frames, broadcast, arbitration, IBI, DISEC/ENEC,
//     Hot-Join, CRCAP1, CRH block, DAA dynamic-address pool)
//   - default read-only window (the CRH block)
//   - regf_rst_val(addr): reset value of every register (unlisted -> 0)
`timescale 1ns/1ps
package i3c_regf_pkg;

    localparam int REGF_CTRL_ADDR        = 0;    // bit 0: ser_rx_tx
    localparam int REGF_FRAMES_ADDR      = 1;
    localparam int BROADCAST_ADDR        = 46;
    localparam int ARBITRATION_ADDR      = 48;
    localparam int IBI_CFG_ADDR          = 50;
    localparam int IBI_PAYLOAD_SIZE_ADDR = 52;
    localparam int DISEC_ADDR            = 56;
    localparam int ENEC_ADDR             = 57;
    localparam int DAA_POOL_FIRST_ADDR   = 80;
    localparam int DAA_POOL_LAST_ADDR    = 100;
    localparam int CRH_BASE_ADDR         = 381;
    localparam int CRH_SIZE              = 12;
    localparam int HJ_EVT_ADDR           = 402;  // bit 3 = Hot-Join enabled
    localparam int HJ_NEVT_ADDR          = 404;  // bit 3 = inverse of the above
    localparam int HJ_CFG_ADDR           = 405;
    localparam int CRCAP1_ADDR           = 409;  // bit 0 = Hot-Join support
    localparam int HJ_BIT                = 3;

    localparam int RO_BASE_DEF = CRH_BASE_ADDR;
    localparam int RO_SIZE_DEF = CRH_SIZE;

    // Reset table. HJ_NEVT bit 3 starts at 1 so the array is already
    // consistent with the hardware-owned Hot-Join rule while in reset.
    function automatic logic [7:0] regf_rst_val(input int addr);
        case (addr)
            REGF_CTRL_ADDR:    regf_rst_val = 8'h01;
            REGF_FRAMES_ADDR:  regf_rst_val = 8'h01;
            BROADCAST_ADDR:    regf_rst_val = 8'hFC;
            ARBITRATION_ADDR:  regf_rst_val = 8'h53;
            CRH_BASE_ADDR + 2: regf_rst_val = 8'h02;
            HJ_NEVT_ADDR:      regf_rst_val = 8'h08;
            default:           regf_rst_val = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/i3c_regf_mp_arbiter.sv
// regf_rr_arbiter
// Round-robin grant for NUM_PORTS requesters.
//   i_regf_clk, i_regf_rst_n : clock, asynchronous active-low reset
//   req_vld                  : per-port request valid
//   gnt                      : one-hot grant (combinational), 0 in reset
//   gnt_idx / gnt_any        : binary index of the grant / any grant
`timescale 1ns/1ps
module regf_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PW        = 1
) (
    input  logic                 i_regf_clk,
    input  logic                 i_regf_rst_n,
    input  logic [NUM_PORTS-1:0] req_vld,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PW-1:0]        gnt_idx,
    output logic                 gnt_any
);

    logic [PW-1:0] rr_ptr_reg;

    // First valid port at or above the pointer, wrapping. Reset gates the
    // grant so valid inputs cannot be accepted while the array is in reset.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            idx = (int'(rr_ptr_reg) + off) % NUM_PORTS;
            if (!gnt_any && req_vld[idx] && i_regf_rst_n) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
        if (!i_regf_rst_n) begin
            rr_ptr_reg <= '0;
        end else if (gnt_any) begin
            rr_ptr_reg <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/i3c_regf_mp.sv
// i3c_regf_mp
// Multi-port WIDTH x DEPTH controller register file with round-robin access.
//   i_regf_clk, i_regf_rst_n        : clock, asynchronous active-low reset
//   i_req_vld/wr/addr/wdata         : per-port requests (addr/wdata flattened)
//   o_req_rdy                       : one-hot grant, accept = vld & rdy
//   o_rsp_vld/o_rsp_rdata/o_rsp_err : registered response, 1 cycle after accept
//   o_regf_num_frames, o_ser_rx_tx,
//   o_regf_hj_cfg, o_regf_hj_support: registered shadows of config registers
// DEPTH must exceed CRCAP1_ADDR (409): the Hot-Join and shadow registers live
// at fixed addresses.
`timescale 1ns/1ps
module i3c_regf_mp
    import i3c_regf_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1024,
    parameter int ADDR      = 10,
    parameter int NUM_PORTS = 2,
    parameter int RO_BASE   = RO_BASE_DEF,
    parameter int RO_SIZE   = RO_SIZE_DEF
) (
    input  logic                       i_regf_clk,
    input  logic                       i_regf_rst_n,
    input  logic [NUM_PORTS-1:0]       i_req_vld,
    input  logic [NUM_PORTS-1:0]       i_req_wr,
    input  logic [NUM_PORTS*ADDR-1:0]  i_req_addr,
    input  logic [NUM_PORTS*WIDTH-1:0] i_req_wdata,
    output logic [NUM_PORTS-1:0]       o_req_rdy,
    output logic [NUM_PORTS-1:0]       o_rsp_vld,
    output logic [WIDTH-1:0]           o_rsp_rdata,
    output logic                       o_rsp_err,
    output logic [WIDTH-1:0]           o_regf_num_frames,
    output logic                       o_ser_rx_tx,
    output logic [2:0]                 o_regf_hj_cfg,
    output logic                       o_regf_hj_support
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] gnt;
    logic [PW-1:0]        gnt_idx;
    logic                 gnt_any;

    regf_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_arb (
        .i_regf_clk   (i_regf_clk),
        .i_regf_rst_n (i_regf_rst_n),
        .req_vld      (i_req_vld),
        .gnt          (gnt),
        .gnt_idx      (gnt_idx),
        .gnt_any      (gnt_any)
    );

    assign o_req_rdy = gnt;

    // Unflatten per-port address/data so the granted port can be selected.
    logic [ADDR-1:0]  req_addr  [NUM_PORTS];
    logic [WIDTH-1:0] req_wdata [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign req_addr[gi]  = i_req_addr[gi*ADDR +: ADDR];
            assign req_wdata[gi] = i_req_wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic             acc_wr;
    logic [ADDR-1:0]  acc_addr;
    logic [WIDTH-1:0] acc_wdata;
    logic             in_range;
    logic             in_ro;
    logic             acc_ok;
    logic             wr_en;

    assign acc_wr    = i_req_wr[gnt_idx];
    assign acc_addr  = req_addr[gnt_idx];
    assign acc_wdata = req_wdata[gnt_idx];
    assign in_range  = int'(acc_addr) < DEPTH;
    assign in_ro     = (int'(acc_addr) >= RO_BASE) && (int'(acc_addr) < RO_BASE + RO_SIZE);
    assign acc_ok    = gnt_any && in_range && !(acc_wr && in_ro);
    assign wr_en     = acc_ok && acc_wr;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             hj_live;

    assign hj_live = mem_reg[CRCAP1_ADDR][0] & mem_reg[HJ_CFG_ADDR][1];

    // The Hot-Join bits are re-written every cycle after any port write, so a
    // write to bit 3 of 402/404 is overridden by the later assignment.
    always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
        if (!i_regf_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= WIDTH'(regf_rst_val(i));
            end
        end else begin
            if (wr_en) begin
                mem_reg[acc_addr] <= acc_wdata;
            end
            mem_reg[HJ_EVT_ADDR][HJ_BIT]  <= hj_live;
            mem_reg[HJ_NEVT_ADDR][HJ_BIT] <= ~hj_live;
        end
    end

    // Hot-Join bits on the read path come from the live inputs, so a read
    // issued right after a write to 405/409 already sees the new value.
    logic [WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem_reg[acc_addr];
        end
        if (int'(acc_addr) == HJ_EVT_ADDR) begin
            rd_word[HJ_BIT] = hj_live;
        end
        if (int'(acc_addr) == HJ_NEVT_ADDR) begin
            rd_word[HJ_BIT] = ~hj_live;
        end
    end

    logic [NUM_PORTS-1:0] rsp_vld_reg;
    logic [WIDTH-1:0]     rsp_rdata_reg;
    logic                 rsp_err_reg;

    always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
        if (!i_regf_rst_n) begin
            rsp_vld_reg   <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_vld_reg   <= gnt;
            rsp_err_reg   <= gnt_any && !acc_ok;
            rsp_rdata_reg <= (acc_ok && !acc_wr) ? rd_word : '0;
        end
    end

    assign o_rsp_vld   = rsp_vld_reg;
    assign o_rsp_rdata = rsp_rdata_reg;
    assign o_rsp_err   = rsp_err_reg;

    logic [WIDTH-1:0] num_frames_reg;
    logic             ser_rx_tx_reg;
    logic [2:0]       hj_cfg_reg;
    logic             hj_support_reg;

    always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
        if (!i_regf_rst_n) begin
            num_frames_reg <= '0;
            ser_rx_tx_reg  <= 1'b0;
            hj_cfg_reg     <= '0;
            hj_support_reg <= 1'b0;
        end else begin
            num_frames_reg <= mem_reg[REGF_FRAMES_ADDR];
            ser_rx_tx_reg  <= mem_reg[REGF_CTRL_ADDR][0];
            hj_cfg_reg     <= mem_reg[HJ_CFG_ADDR][2:0];
            hj_support_reg <= mem_reg[CRCAP1_ADDR][0];
        end
    end

    assign o_regf_num_frames = num_frames_reg;
    assign o_ser_rx_tx       = ser_rx_tx_reg;
    assign o_regf_hj_cfg     = hj_cfg_reg;
    assign o_regf_hj_support = hj_support_reg;

endmodule

// File: tb/tb_i3c_regf_mp.sv
`timescale 1ns/1ps
module tb_i3c_regf_mp;

    localparam int NP = 4;
    localparam int DP = 1000;
    localparam int AW = 10;
    localparam int DW = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NP-1:0]      req_vld = '0;
    logic [NP-1:0]      req_wr = '0;
    logic [NP*AW-1:0]   req_addr = '0;
    logic [NP*DW-1:0]   req_wdata = '0;
    logic [NP-1:0]      req_rdy;
    logic [NP-1:0]      rsp_vld;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic [DW-1:0]      num_frames;
    logic               ser_rx_tx;
    logic [2:0]         hj_cfg;
    logic               hj_support;

    i3c_regf_mp #(
        .WIDTH(DW), .DEPTH(DP), .ADDR(AW), .NUM_PORTS(NP), .RO_BASE(381), .RO_SIZE(12)
    ) dut (
        .i_regf_clk        (clk),
        .i_regf_rst_n      (rst_n),
        .i_req_vld         (req_vld),
        .i_req_wr          (req_wr),
        .i_req_addr        (req_addr),
        .i_req_wdata       (req_wdata),
        .o_req_rdy         (req_rdy),
        .o_rsp_vld         (rsp_vld),
        .o_rsp_rdata       (rsp_rdata),
        .o_rsp_err         (rsp_err),
        .o_regf_num_frames (num_frames),
        .o_ser_rx_tx       (ser_rx_tx),
        .o_regf_hj_cfg     (hj_cfg),
        .o_regf_hj_support (hj_support)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [7:0]  mm [1024];
    int          ptr;
    logic [NP-1:0] e_vld;
    logic [7:0]  e_rdata;
    logic        e_err;
    logic [7:0]  lag_frames;
    logic        lag_ser;
    logic [2:0]  lag_hjcfg;
    logic        lag_hjsup;
    int          obs_gnt;

    // pending request per port (held until granted)
    logic        p_vld [NP];
    logic        p_wr [NP];
    int          p_addr [NP];
    logic [7:0]  p_wdata [NP];

    function automatic void model_reset();
        for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
        mm[0]   = 8'h01;
        mm[1]   = 8'h01;
        mm[46]  = 8'hFC;
        mm[48]  = 8'h53;
        mm[383] = 8'h02;
        ptr = 0;
        e_vld = '0;
        e_rdata = '0;
        e_err = 1'b0;
    endfunction

    function automatic logic hj_on();
        return mm[409][0] & mm[405][1];
    endfunction

    function automatic logic [7:0] model_read(input int a);
        logic [7:0] v;
        v = mm[a];
        if (a == 402) v[3] = hj_on();
        if (a == 404) v[3] = ~hj_on();
        return v;
    endfunction

    function automatic void lag_load();
        lag_frames = mm[1];
        lag_ser    = mm[0][0];
        lag_hjcfg  = mm[405][2:0];
        lag_hjsup  = mm[409][0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int p, input logic wr, input int a, input logic [7:0] d);
        p_vld[p] = 1'b1;
        p_wr[p] = wr;
        p_addr[p] = a;
        p_wdata[p] = d;
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            req_vld[p] = p_vld[p];
            req_wr[p] = p_wr[p];
            req_addr[p*AW +: AW] = AW'(p_addr[p]);
            req_wdata[p*DW +: DW] = p_wdata[p];
        end
    endtask

    // One clock cycle: drive, check grant/response/shadows at negedge,
    // advance the model, then retire the granted request after the edge.
    task automatic step();
        int g;
        int idx;
        logic [NP-1:0] eg;
        drive();
        @(negedge clk);
        g = -1;
        for (int off = 0; off < NP; off++) begin
            idx = (ptr + off) % NP;
            if (g < 0 && p_vld[idx]) g = idx;
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("grant", req_rdy, eg);
        obs_gnt = -1;
        for (int p = 0; p < NP; p++) if (req_rdy[p]) obs_gnt = p;
        chk("rsp_vld", rsp_vld, e_vld);
        if (e_vld != '0) begin
            chk("rsp_rdata", rsp_rdata, e_rdata);
            chk("rsp_err", rsp_err, e_err);
        end
        chk("sh_frames", num_frames, lag_frames);
        chk("sh_ser", ser_rx_tx, lag_ser);
        chk("sh_hjcfg", hj_cfg, lag_hjcfg);
        chk("sh_hjsup", hj_support, lag_hjsup);
        lag_load();
        e_vld = '0;
        if (g >= 0) begin
            e_vld[g] = 1'b1;
            e_err = (p_addr[g] >= DP) || (p_wr[g] && p_addr[g] >= 381 && p_addr[g] < 393);
            e_rdata = 8'h00;
            if (!e_err && !p_wr[g]) e_rdata = model_read(p_addr[g]);
            if (!e_err && p_wr[g]) mm[p_addr[g]] = p_wdata[g];
            ptr = (g + 1) % NP;
            $display("txn port=%0d %s addr=%0d wdata=%02h exp_rdata=%02h exp_err=%0b",
                     g, p_wr[g] ? "WR" : "RD", p_addr[g], p_wdata[g], e_rdata, e_err);
        end
        @(posedge clk);
        #1;
        if (g >= 0) p_vld[g] = 1'b0;
    endtask

    int gq[$];
    int sp[8] = '{0, 1, 402, 404, 405, 409, 46, 48};
    int exp_order[4] = '{2, 3, 0, 1};

    initial begin
        int a;
        for (int p = 0; p < NP; p++) begin
            p_vld[p] = 1'b0; p_wr[p] = 1'b0; p_addr[p] = 0; p_wdata[p] = 8'h00;
        end
        model_reset();

        // ---- reset state, with a valid request held during reset ----
        rst_n = 1'b0;
        req(0, 1'b0, 46, 8'h00);
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", req_rdy, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_frames", num_frames, 0);
        chk("rst_ser", ser_rx_tx, 0);
        chk("rst_hjcfg", hj_cfg, 0);
        chk("rst_hjsup", hj_support, 0);
        p_vld[0] = 1'b0;
        drive();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lag_load();

        // ---- reset-table reads ----
        req(0, 1'b0, 46, 8'h00); step();
        req(0, 1'b0, 48, 8'h00); step();
        step();

        // ---- two ports writing continuously: grants alternate ----
        gq.delete();
        begin
            int start;
            start = ptr;
            for (int i = 0; i < 6; i++) begin
                req(0, 1'b1, 10, 8'hA5);
                req(1, 1'b1, 11, 8'h5A);
                step();
                gq.push_back(obs_gnt);
            end
            for (int i = 0; i < 6; i++) chk("alt_grant", gq[i], (start + i) % 2);
        end
        p_vld[0] = 1'b0; p_vld[1] = 1'b0;
        req(0, 1'b0, 10, 8'h00); step();
        req(1, 1'b0, 11, 8'h00); step();

        // ---- RO window and out-of-range ----
        req(0, 1'b1, 383, 8'hFF); step();
        req(0, 1'b0, 383, 8'h00); step();
        req(0, 1'b0, 1023, 8'h00); step();

        // ---- Hot-Join hardware-owned bits ----
        req(0, 1'b1, 409, 8'h01); step();
        req(0, 1'b1, 405, 8'h02); step();
        req(0, 1'b0, 402, 8'h00); step();
        req(0, 1'b0, 404, 8'h00); step();
        req(0, 1'b1, 402, 8'h00); step();
        req(0, 1'b0, 402, 8'h00); step();

        // ---- frames shadow follows a write two edges after acceptance ----
        req(0, 1'b1, 1, 8'h07); step();
        step();
        chk("frames_shadow", num_frames, 8'h07);
        step();

        // ---- all four ports valid from pointer 2 ----
        req(1, 1'b0, 5, 8'h00); step();
        gq.delete();
        for (int p = 0; p < NP; p++) req(p, 1'b0, 3 * p, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            gq.push_back(obs_gnt);
        end
        for (int i = 0; i < 4; i++) chk("rr_order", gq[i], exp_order[i]);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 250; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!p_vld[p] && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 3))
                        0: a = $urandom_range(0, 1023);
                        1: a = $urandom_range(378, 395);
                        2: a = sp[$urandom_range(0, 7)];
                        default: a = $urandom_range(0, 15);
                    endcase
                    req(p, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
                end
            end
            step();
        end
        for (int p = 0; p < NP; p++) p_vld[p] = 1'b0;
        step();

        // ---- reset asserted while a read response is pending ----
        req(0, 1'b0, 1, 8'h00); step();
        chk("pend_rsp_vld", rsp_vld, 1);
        req(2, 1'b0, 7, 8'h00);
        drive();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_vld", rsp_vld, 0);
        chk("mid_rst_rdy", req_rdy, 0);
        chk("mid_rst_frames", num_frames, 0);
        p_vld[2] = 1'b0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("post_rst_frames", num_frames, mm[1]);
        chk("post_rst_hjsup", hj_support, mm[409][0]);
        lag_load();
        req(0, 1'b0, 1, 8'h00); step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i3c_regf_mp.md
# i3c_regf_mp

Multi-port successor of the controller register file: a parametrised WIDTH×DEPTH register array shared by NUM_PORTS requesters (SDR/HDR engines, DAA, CRH, IBI) through valid/ready request ports with round-robin arbitration. It adds registered read responses, write protection for a read-only window, out-of-range error reporting and hardware-owned Hot-Join bits. Static configuration fields are exported as registered shadow outputs.

## Interface
- WIDTH, 8, register width in bits
- DEPTH, 1024, number of registers
- ADDR, 10, address width; DEPTH ≤ 2^ADDR
- NUM_PORTS, 2, requester count, 1..8
- RO_BASE, 381, first read-only address; RO_BASE..RO_BASE+RO_SIZE-1 reject writes
- RO_SIZE, 12, read-only window size
---
- i_regf_clk  in  1  clock
- i_regf_rst_n  in  1  asynchronous, active-low reset
- i_req_vld  in  NUM_PORTS  per-port request valid
- i_req_wr  in  NUM_PORTS  1 = write, 0 = read
- i_req_addr  in  NUM_PORTS*ADDR  flattened addresses; port p occupies [p*ADDR +: ADDR]
- i_req_wdata  in  NUM_PORTS*WIDTH  flattened write data
- o_req_rdy  out  NUM_PORTS  one-hot grant; the request is accepted when vld & rdy
- o_rsp_vld  out  NUM_PORTS  one-hot response strobe, one cycle after acceptance
- o_rsp_rdata  out  WIDTH  read data; 0 for writes and errors
- o_rsp_err  out  1  accepted request was out of range or a write to the read-only window
- o_regf_num_frames  out  WIDTH  shadow of reg 1
- o_ser_rx_tx  out  1  shadow of reg 0 bit 0
- o_regf_hj_cfg  out  3  shadow of reg 405[2:0]
- o_regf_hj_support  out  1  shadow of reg 409[0]

## Operation
- Arbiter: round-robin pointer rr_ptr, reset 0.
  - Grant goes to the first port with vld=1, searching upward from rr_ptr and wrapping.
  - o_req_rdy is combinational from i_req_vld and rr_ptr.
  - After a grant to port g, rr_ptr becomes (g+1) mod NUM_PORTS. With no grant, rr_ptr holds.
- At most one access per cycle. Ungranted ports hold vld, addr and wdata stable until granted.
- Accepted read, addr < DEPTH: the array word is returned next cycle on o_rsp_rdata with o_rsp_err=0.
- Accepted write, addr < DEPTH and outside the RO window: the array is updated at the clock edge; the response has o_rsp_err=0.
- Accepted request with addr ≥ DEPTH, or a write inside the RO window: the array is unchanged and the response has o_rsp_err=1, rdata=0.
- Hot-Join bits are hardware-owned. Every cycle:
  - reg402[3] = reg409[0] & reg405[1].
  - reg404[3] = its inverse.
  - Writes to these two bits are discarded; the other bits of 402 and 404 take the write data.
- Reset: the array loads the package reset table. Every entry not listed in the table is 0. No X values.

## Timing
- Reset values:
  - o_req_rdy = 0 (valid inputs are ignored while reset is asserted), o_rsp_vld = 0, o_rsp_rdata = 0, o_rsp_err = 0.
  - Shadows take their table values one cycle after reset release. They are 0 during reset.
- Latency:
  - Read: 1 cycle from acceptance to o_rsp_vld.
  - Write: visible to a read accepted in the next cycle.
  - Shadows: 1 cycle after the array update.
- Throughput: one request per cycle aggregate. A single always-valid port with no contention gets back-to-back grants.
- Simultaneous requests from all ports are served in pointer order; each port waits at most NUM_PORTS-1 cycles.
- Read and write to the same address in consecutive cycles by different ports: ordering follows grant order; there is no bypass hazard.
- Reset asserted mid-transaction: the pending response is dropped and o_rsp_vld goes low immediately (asynchronous).
- Responses are not back-pressured; requesters must sink o_rsp_vld.

## Structure
- Package i3c_regf_pkg holds:
  - Address constants: frames, broadcast, arbitration, IBI config, payload size, DISEC/ENEC, HJ_CFG, CRCAP1, CRH block, DAA dynamic-address pool 80..100.
  - The reset-value function regf_rst_val(addr).
  - The RO_BASE/RO_SIZE defaults.
- Sub-module regf_rr_arbiter (parameter NUM_PORTS) contains the pointer and the grant logic. The top level contains the array, the response register and the shadows.

## Test plan
- Reset, then read addr 46 and 48 on port 0 → rdata 0xFC, then 0x53; err=0; o_rsp_vld 1 cycle after rdy.
- Port 0 and port 1 both write continuously (0xA5 to addr 10, 0x5A to addr 11) → grants alternate 0,1,0,1; final reads return 0xA5 and 0x5A.
- Write 0xFF to addr 383 (RO window) → err=1, subsequent read of 383 returns 0x02. Read of addr 1023 with DEPTH=1000 → err=1, rdata=0.
- Write reg409=0x01 and reg405=0x02 → reg402[3]=1 and reg404[3]=0 within 1 cycle. Write reg402=0x00 → bit3 reads back 1.
- Write reg1=0x07 → o_regf_num_frames=0x07 on the second edge after acceptance. Assert reset during a pending read → o_rsp_vld=0 and the shadow returns to its reset value.
- Configure NUM_PORTS=4 with all ports valid from rr_ptr=2 → grant order 2,3,0,1.
